multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter ALU_OP_W, default 4, ALU operation code width; SHALL be at least 4.
REQ-002 Parameter TIMEOUT, default 15, maximum wait cycles for mem_ready_i in FETCH or MEM; range 1..255.
REQ-003 clk_i  in  1  clock; all state changes on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-low.
REQ-005 instr_op_i  in  6  opcode field from the instruction register.
REQ-006 instr_funct_i  in  6  funct field from the instruction register.
REQ-007 mem_ready_i  in  1  memory access complete in the current cycle.
REQ-008 branch_cond_i  in  1  datapath comparator result for the current branch.
REQ-009 Outputs: ir_write_o 1; pc_write_o 1; pc_src_o 2 (0 PC+4, 1 branch target, 2 jump target, 3 rs); iord_o 1 (memory address: 0 PC, 1 ALU result); mem_read_o 1; mem_write_o 1.
REQ-010 Outputs: reg_write_o 1; reg_dst_o 2 (0 rt, 1 rd, 2 r31); mem_to_reg_o 2 (0 ALU, 1 MEM, 2 immediate, 3 PC+4); alu_src_o 1 (0 reg, 1 imm); alu_op_o ALU_OP_W; branch_type_o 2 (0 BEQ, 1 BLE, 2 BLT, 3 BNEZ).
REQ-011 Outputs: state_o 3, current state; illegal_o 1, illegal opcode pulse; timeout_o 1, timeout pulse.

Function
REQ-012 States and encodings SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5; IDLE SHALL go to FETCH unconditionally.
REQ-013 FETCH: mem_read_o=1 and iord_o=0; when mem_ready_i=1, ir_write_o=1, pc_write_o=1 and pc_src_o=0 in that same cycle, then go to DECODE.
REQ-014 DECODE: opcode and funct SHALL be latched internally, and later states SHALL use only the latched values.
REQ-015 DECODE, op 2 (j): pc_write_o=1, pc_src_o=2; go to FETCH.
REQ-016 DECODE, op 3 (jal): pc_write_o=1, pc_src_o=2, reg_write_o=1, reg_dst_o=2, mem_to_reg_o=3; go to FETCH.
REQ-017 DECODE, op 0 with funct 0x08 (jr): pc_write_o=1, pc_src_o=3; go to FETCH.
REQ-018 DECODE, any opcode not in {0,2,3,4,5,6,7,8,13,15,35,43}: illegal_o=1 for one cycle; go to FETCH; no other write strobe asserted.
REQ-019 DECODE, all other legal opcodes: go to EXEC.
REQ-020 EXEC alu_op_o, zero-extended to ALU_OP_W: R-type 0, beq 2, bnez 3, blt 4, ble 5, addi 6, ori 7, lw 8, sw 9; li 0. alu_src_o=1 for addi, ori, lw and sw, otherwise 0.
REQ-021 EXEC, branches (ops 4, 5, 6, 7): branch_type_o = 0, 3, 2, 1 respectively; pc_src_o=1; pc_write_o=branch_cond_i (combinational); go to FETCH.
REQ-022 EXEC: R-type, addi, ori and li go to WB; lw and sw go to MEM.
REQ-023 MEM: iord_o=1; mem_read_o=1 for lw, mem_write_o=1 for sw; both held until mem_ready_i=1; then lw goes to WB and sw goes to FETCH.
REQ-024 WB: reg_write_o=1 for exactly one cycle; reg_dst_o=1 for R-type, else 0; mem_to_reg_o=1 for lw, 2 for li, else 0; go to FETCH.
REQ-025 Wait counter: cleared on entry to FETCH or MEM; increments each cycle in that state while mem_ready_i=0.
REQ-026 If the wait counter reaches TIMEOUT with mem_ready_i=0, timeout_o SHALL pulse for one cycle, no strobe is asserted that cycle, and the next state is FETCH (FETCH retries; MEM aborts).
REQ-027 When mem_ready_i=1 in the same cycle the wait counter reaches TIMEOUT, the access completes normally and there is no timeout.
REQ-028 Every output not explicitly driven in the current state SHALL be 0; no X SHALL appear on any output.

Reset
REQ-029 rst_i=0 SHALL force state IDLE and wait counter 0 immediately, asynchronously, including mid-access; all outputs SHALL be 0 while rst_i=0 and while in IDLE.
REQ-030 After rst_i rises, the first rising clock edge SHALL enter FETCH.

Verification
REQ-031 Reset asserted during lw MEM wait -> state_o=0 and mem_read_o=0 within the same cycle; state_o=1 one edge after release.
REQ-032 addi (op 8), mem_ready_i held 1 -> state_o sequence 1,2,3,5,1; alu_op_o=6 and alu_src_o=1 in EXEC; reg_write_o=1 only in WB with reg_dst_o=0.
REQ-033 lw (op 35), mem_ready_i rises on the 4th MEM cycle -> mem_read_o=1 and iord_o=1 for 4 cycles; WB with mem_to_reg_o=1.
REQ-034 beq (op 4) -> with branch_cond_i=1, EXEC shows pc_write_o=1, pc_src_o=1, branch_type_o=0; with branch_cond_i=0, pc_write_o=0; next state FETCH in both cases.
REQ-035 TIMEOUT=4, sw (op 43), mem_ready_i held 0 -> mem_write_o=1 for 4 cycles, timeout_o pulses once, state_o=1 next cycle.
REQ-036 op 9 -> illegal_o=1 for one cycle in DECODE and no write strobes; jal (op 3) -> reg_dst_o=2, mem_to_reg_o=3, pc_src_o=2 in DECODE.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath.
// The master modport is the controller side, the slave modport the datapath side.
interface multicycle_ctrl_if #(
  parameter int unsigned ALU_OP_W = 4
);
  logic [5:0]          instr_op_i;
  logic [5:0]          instr_funct_i;
  logic                mem_ready_i;
  logic                branch_cond_i;

  logic                ir_write_o;
  logic                pc_write_o;
  logic [1:0]          pc_src_o;
  logic                iord_o;
  logic                mem_read_o;
  logic                mem_write_o;
  logic                reg_write_o;
  logic [1:0]          reg_dst_o;
  logic [1:0]          mem_to_reg_o;
  logic                alu_src_o;
  logic [ALU_OP_W-1:0] alu_op_o;
  logic [1:0]          branch_type_o;
  logic [2:0]          state_o;
  logic                illegal_o;
  logic                timeout_o;

  modport master (
    input  instr_op_i, instr_funct_i, mem_ready_i, branch_cond_i,
    output ir_write_o, pc_write_o, pc_src_o, iord_o, mem_read_o, mem_write_o,
           reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_o, alu_op_o,
           branch_type_o, state_o, illegal_o, timeout_o
  );

  modport slave (
    output instr_op_i, instr_funct_i, mem_ready_i, branch_cond_i,
    input  ir_write_o, pc_write_o, pc_src_o, iord_o, mem_read_o, mem_write_o,
           reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_o, alu_op_o,
           branch_type_o, state_o, illegal_o, timeout_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch/decode/execute/memory/writeback sequencing
// with a bounded wait on memory handshakes.
module multicycle_ctrl #(
  parameter int unsigned ALU_OP_W = 4,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  multicycle_ctrl_if.master bus_io
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5
  } state_e;

  localparam logic [5:0] OpRtype = 6'd0;
  localparam logic [5:0] OpJ     = 6'd2;
  localparam logic [5:0] OpJal   = 6'd3;
  localparam logic [5:0] OpBeq   = 6'd4;
  localparam logic [5:0] OpBnez  = 6'd5;
  localparam logic [5:0] OpBlt   = 6'd6;
  localparam logic [5:0] OpBle   = 6'd7;
  localparam logic [5:0] OpAddi  = 6'd8;
  localparam logic [5:0] OpOri   = 6'd13;
  localparam logic [5:0] OpLi    = 6'd15;
  localparam logic [5:0] OpLw    = 6'd35;
  localparam logic [5:0] OpSw    = 6'd43;
  localparam logic [5:0] FunctJr = 6'h08;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [5:0] op_q, funct_q;

  logic                ir_write, pc_write, iord, mem_read, mem_write, reg_write;
  logic                alu_src, illegal, timeout;
  logic [1:0]          pc_src, reg_dst, mem_to_reg, branch_type;
  logic [ALU_OP_W-1:0] alu_op;
  logic                timeout_hit;

  function automatic logic op_legal(logic [5:0] op);
    case (op)
      OpRtype, OpJ, OpJal, OpBeq, OpBnez, OpBlt, OpBle,
      OpAddi, OpOri, OpLi, OpLw, OpSw: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  // A ready in the same cycle the count hits the limit still completes the access.
  assign timeout_hit = (wait_q == TimeoutCnt) && !bus_io.mem_ready_i;

  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'd0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 2'd0;
    mem_to_reg  = 2'd0;
    alu_src     = 1'b0;
    alu_op      = '0;
    branch_type = 2'd0;
    illegal     = 1'b0;
    timeout     = 1'b0;

    unique case (state_q)
      StIdle: state_d = StFetch;

      StFetch: begin
        if (timeout_hit) begin
          timeout = 1'b1;
          state_d = StFetch;
        end else begin
          mem_read = 1'b1;
          if (bus_io.mem_ready_i) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = StDecode;
          end else begin
            wait_d = 8'(wait_q + 8'd1);
          end
        end
      end

      // Decode sees the freshly loaded instruction register directly.
      StDecode: begin
        state_d = StFetch;
        if (bus_io.instr_op_i == OpJ) begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
        end else if (bus_io.instr_op_i == OpJal) begin
          pc_write   = 1'b1;
          pc_src     = 2'd2;
          reg_write  = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd3;
        end else if (bus_io.instr_op_i == OpRtype && bus_io.instr_funct_i == FunctJr) begin
          pc_write = 1'b1;
          pc_src   = 2'd3;
        end else if (!op_legal(bus_io.instr_op_i)) begin
          illegal = 1'b1;
        end else begin
          state_d = StExec;
        end
      end

      StExec: begin
        unique case (op_q)
          OpRtype: state_d = (funct_q == FunctJr) ? StFetch : StWb;
          OpBeq: begin
            alu_op      = ALU_OP_W'(4'd2);
            branch_type = 2'd0;
          end
          OpBnez: begin
            alu_op      = ALU_OP_W'(4'd3);
            branch_type = 2'd3;
          end
          OpBlt: begin
            alu_op      = ALU_OP_W'(4'd4);
            branch_type = 2'd2;
          end
          OpBle: begin
            alu_op      = ALU_OP_W'(4'd5);
            branch_type = 2'd1;
          end
          OpAddi: begin
            alu_op  = ALU_OP_W'(4'd6);
            alu_src = 1'b1;
            state_d = StWb;
          end
          OpOri: begin
            alu_op  = ALU_OP_W'(4'd7);
            alu_src = 1'b1;
            state_d = StWb;
          end
          OpLi: state_d = StWb;
          OpLw: begin
            alu_op  = ALU_OP_W'(4'd8);
            alu_src = 1'b1;
            state_d = StMem;
          end
          OpSw: begin
            alu_op  = ALU_OP_W'(4'd9);
            alu_src = 1'b1;
            state_d = StMem;
          end
          default: state_d = StFetch;
        endcase
        if (op_q inside {OpBeq, OpBnez, OpBlt, OpBle}) begin
          pc_src   = 2'd1;
          pc_write = bus_io.branch_cond_i;
          state_d  = StFetch;
        end
      end

      StMem: begin
        if (timeout_hit) begin
          timeout = 1'b1;
          state_d = StFetch;
        end else begin
          iord      = 1'b1;
          mem_read  = (op_q == OpLw);
          mem_write = (op_q == OpSw);
          if (bus_io.mem_ready_i) begin
            state_d = (op_q == OpLw) ? StWb : StFetch;
          end else begin
            wait_d = 8'(wait_q + 8'd1);
          end
        end
      end

      StWb: begin
        reg_write = 1'b1;
        reg_dst   = (op_q == OpRtype) ? 2'd1 : 2'd0;
        if (op_q == OpLw) begin
          mem_to_reg = 2'd1;
        end else if (op_q == OpLi) begin
          mem_to_reg = 2'd2;
        end
        state_d = StFetch;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      wait_q  <= '0;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == StDecode) begin
        op_q    <= bus_io.instr_op_i;
        funct_q <= bus_io.instr_funct_i;
      end
    end
  end

  assign bus_io.ir_write_o    = ir_write;
  assign bus_io.pc_write_o    = pc_write;
  assign bus_io.pc_src_o      = pc_src;
  assign bus_io.iord_o        = iord;
  assign bus_io.mem_read_o    = mem_read;
  assign bus_io.mem_write_o   = mem_write;
  assign bus_io.reg_write_o   = reg_write;
  assign bus_io.reg_dst_o     = reg_dst;
  assign bus_io.mem_to_reg_o  = mem_to_reg;
  assign bus_io.alu_src_o     = alu_src;
  assign bus_io.alu_op_o      = alu_op;
  assign bus_io.branch_type_o = branch_type;
  assign bus_io.state_o       = state_q;
  assign bus_io.illegal_o     = illegal;
  assign bus_io.timeout_o     = timeout;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table plus hand-written
// timeout, boundary and asynchronous-reset sequences.
module tb_multicycle_ctrl;

  localparam logic [2:0] SIdle = 3'd0, SFetch = 3'd1, SDecode = 3'd2;
  localparam logic [2:0] SExec = 3'd3, SMem = 3'd4, SWb = 3'd5;

  typedef struct packed {
    logic [2:0] st;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src;
    logic [3:0] alu_op;
    logic [1:0] branch_type;
    logic       illegal;
    logic       timeout;
  } out_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       rdy;
    logic       cond;
    out_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  out_t act;
  vec_t tbl[$];

  multicycle_ctrl_if #(.ALU_OP_W(4)) bus ();

  multicycle_ctrl #(.ALU_OP_W(4), .TIMEOUT(4)) dut (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  assign act = {bus.state_o, bus.ir_write_o, bus.pc_write_o, bus.pc_src_o, bus.iord_o,
                bus.mem_read_o, bus.mem_write_o, bus.reg_write_o, bus.reg_dst_o,
                bus.mem_to_reg_o, bus.alu_src_o, bus.alu_op_o, bus.branch_type_o,
                bus.illegal_o, bus.timeout_o};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step(input logic [5:0] op, input logic [5:0] funct, input logic rdy,
                      input logic cond);
    @(negedge clk);
    bus.instr_op_i    = op;
    bus.instr_funct_i = funct;
    bus.mem_ready_i   = rdy;
    bus.branch_cond_i = cond;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_ready_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_idle", 32'(act), 32'd0);
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] funct, input logic rdy,
                              input logic cond, input logic [2:0] st);
    vec_t r;
    r.op    = op;
    r.funct = funct;
    r.rdy   = rdy;
    r.cond  = cond;
    r.e     = '0;
    r.e.st  = st;
    return r;
  endfunction

  function automatic vec_t fetch_v();
    vec_t r;
    r = mk(6'd0, 6'd0, 1'b1, 1'b0, SFetch);
    r.e.mem_read = 1'b1;
    r.e.ir_write = 1'b1;
    r.e.pc_write = 1'b1;
    return r;
  endfunction

  // Branch: FETCH, DECODE, EXEC with the given condition.
  task automatic add_branch(input logic [5:0] op, input logic cond, input logic [3:0] aop,
                            input logic [1:0] bt);
    vec_t v;
    tbl.push_back(fetch_v());
    tbl.push_back(mk(op, 6'd0, 1'b1, 1'b0, SDecode));
    v = mk(6'd9, 6'd0, 1'b1, cond, SExec);
    v.e.alu_op = aop; v.e.branch_type = bt; v.e.pc_src = 2'd1; v.e.pc_write = cond;
    tbl.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   cnt_a, cnt_b;

    // addi; later-state inputs carry garbage opcodes to prove the latch is used
    tbl.push_back(fetch_v());
    tbl.push_back(mk(6'd8, 6'd0, 1'b1, 1'b0, SDecode));
    v = mk(6'd9, 6'd0, 1'b1, 1'b0, SExec); v.e.alu_op = 4'd6; v.e.alu_src = 1'b1;
    tbl.push_back(v);
    v = mk(6'd9, 6'd0, 1'b1, 1'b0, SWb); v.e.reg_write = 1'b1; tbl.push_back(v);
    // lw, ready on the 4th MEM cycle
    tbl.push_back(fetch_v());
    tbl.push_back(mk(6'd35, 6'd0, 1'b1, 1'b0, SDecode));
    v = mk(6'd0, 6'd0, 1'b1, 1'b0, SExec); v.e.alu_op = 4'd8; v.e.alu_src = 1'b1;
    tbl.push_back(v);
    for (int k = 0; k < 4; k++) begin
      v = mk(6'd43, 6'd0, (k == 3), 1'b0, SMem); v.e.iord = 1'b1; v.e.mem_read = 1'b1;
      tbl.push_back(v);
    end
    v = mk(6'd43, 6'd0, 1'b1, 1'b0, SWb); v.e.reg_write = 1'b1; v.e.mem_to_reg = 2'd1;
    tbl.push_back(v);
    // branches
    add_branch(6'd4, 1'b1, 4'd2, 2'd0);
    add_branch(6'd4, 1'b0, 4'd2, 2'd0);
    add_branch(6'd5, 1'b1, 4'd3, 2'd3);
    add_branch(6'd6, 1'b1, 4'd4, 2'd2);
    add_branch(6'd7, 1'b0, 4'd5, 2'd1);
    // illegal op 9
    tbl.push_back(fetch_v());
    v = mk(6'd9, 6'd0, 1'b1, 1'b0, SDecode); v.e.illegal = 1'b1; tbl.push_back(v);
    // jal
    tbl.push_back(fetch_v());
    v = mk(6'd3, 6'd0, 1'b1, 1'b0, SDecode);
    v.e.pc_write = 1'b1; v.e.pc_src = 2'd2; v.e.reg_write = 1'b1;
    v.e.reg_dst = 2'd2; v.e.mem_to_reg = 2'd3;
    tbl.push_back(v);
    // j
    tbl.push_back(fetch_v());
    v = mk(6'd2, 6'd0, 1'b1, 1'b0, SDecode); v.e.pc_write = 1'b1; v.e.pc_src = 2'd2;
    tbl.push_back(v);
    // jr
    tbl.push_back(fetch_v());
    v = mk(6'd0, 6'h08, 1'b1, 1'b0, SDecode); v.e.pc_write = 1'b1; v.e.pc_src = 2'd3;
    tbl.push_back(v);
    // R-type add
    tbl.push_back(fetch_v());
    tbl.push_back(mk(6'd0, 6'h20, 1'b1, 1'b0, SDecode));
    tbl.push_back(mk(6'd2, 6'h08, 1'b1, 1'b0, SExec));
    v = mk(6'd2, 6'h08, 1'b1, 1'b0, SWb); v.e.reg_write = 1'b1; v.e.reg_dst = 2'd1;
    tbl.push_back(v);
    // ori
    tbl.push_back(fetch_v());
    tbl.push_back(mk(6'd13, 6'd0, 1'b1, 1'b0, SDecode));
    v = mk(6'd0, 6'd0, 1'b1, 1'b0, SExec); v.e.alu_op = 4'd7; v.e.alu_src = 1'b1;
    tbl.push_back(v);
    v = mk(6'd0, 6'd0, 1'b1, 1'b0, SWb); v.e.reg_write = 1'b1; tbl.push_back(v);
    // li
    tbl.push_back(fetch_v());
    tbl.push_back(mk(6'd15, 6'd0, 1'b1, 1'b0, SDecode));
    tbl.push_back(mk(6'd0, 6'd0, 1'b1, 1'b0, SExec));
    v = mk(6'd0, 6'd0, 1'b1, 1'b0, SWb); v.e.reg_write = 1'b1; v.e.mem_to_reg = 2'd2;
    tbl.push_back(v);
    // sw, ready on the 2nd MEM cycle
    tbl.push_back(fetch_v());
    tbl.push_back(mk(6'd43, 6'd0, 1'b1, 1'b0, SDecode));
    v = mk(6'd0, 6'd0, 1'b1, 1'b0, SExec); v.e.alu_op = 4'd9; v.e.alu_src = 1'b1;
    tbl.push_back(v);
    for (int k = 0; k < 2; k++) begin
      v = mk(6'd35, 6'd0, (k == 1), 1'b0, SMem); v.e.iord = 1'b1; v.e.mem_write = 1'b1;
      tbl.push_back(v);
    end
    v = mk(6'd0, 6'd0, 1'b0, 1'b0, SFetch); v.e.mem_read = 1'b1; tbl.push_back(v);

    // Reset: outputs all zero while held
    rst_n = 1'b1;
    bus.instr_op_i = '0; bus.instr_funct_i = '0; bus.mem_ready_i = 1'b1;
    bus.branch_cond_i = 1'b1;
    #1 rst_n = 1'b0;
    #2 chk("reset_async", 32'(act), 32'd0);
    @(posedge clk); #1;
    chk("reset_held", 32'(act), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("idle_after_release", 32'(act), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      step(v.op, v.funct, v.rdy, v.cond);
      chk($sformatf("vec%0d", i), 32'(act), 32'(v.e));
    end

    // sw with memory never ready: 4 write cycles, then a single timeout pulse
    do_reset();
    step(6'd0, 6'd0, 1'b1, 1'b0);
    step(6'd43, 6'd0, 1'b1, 1'b0);
    step(6'd0, 6'd0, 1'b1, 1'b0);
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 4; k++) begin
      step(6'd35, 6'd0, 1'b0, 1'b0);
      if (bus.mem_write_o === 1'b1 && bus.iord_o === 1'b1 && bus.state_o === SMem) cnt_a++;
      if (bus.timeout_o !== 1'b0) cnt_b++;
    end
    chk("sw_to_write_cycles", 32'(cnt_a), 32'd4);
    step(6'd35, 6'd0, 1'b0, 1'b0);
    chk("sw_to_pulse", 32'(act), 32'({SMem, 20'd0, 1'b1}));
    if (bus.timeout_o !== 1'b0) cnt_b++;
    step(6'd35, 6'd0, 1'b0, 1'b0);
    if (bus.timeout_o !== 1'b0) cnt_b++;
    chk("sw_to_pulse_count", 32'(cnt_b), 32'd1);
    chk("sw_to_next_state", 32'(bus.state_o), 32'(SFetch));

    // lw with ready exactly when the count reaches the limit completes normally
    do_reset();
    step(6'd0, 6'd0, 1'b1, 1'b0);
    step(6'd35, 6'd0, 1'b1, 1'b0);
    step(6'd0, 6'd0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step(6'd0, 6'd0, 1'b0, 1'b0);
    step(6'd0, 6'd0, 1'b1, 1'b0);
    chk("lw_edge_no_timeout", 32'({bus.timeout_o, bus.mem_read_o, bus.iord_o}), 32'b011);
    step(6'd0, 6'd0, 1'b1, 1'b0);
    chk("lw_edge_wb", 32'({bus.state_o, bus.reg_write_o, bus.mem_to_reg_o}),
        32'({SWb, 1'b1, 2'd1}));

    // FETCH timeout retries with a freshly cleared counter
    do_reset();
    for (int k = 0; k < 4; k++) step(6'd0, 6'd0, 1'b0, 1'b0);
    chk("fetch_wait_read", 32'({bus.state_o, bus.mem_read_o, bus.timeout_o}),
        32'({SFetch, 2'b10}));
    step(6'd0, 6'd0, 1'b0, 1'b0);
    chk("fetch_to_pulse", 32'(act), 32'({SFetch, 20'd0, 1'b1}));
    cnt_a = 0;
    for (int k = 0; k < 4; k++) begin
      step(6'd0, 6'd0, 1'b0, 1'b0);
      if (bus.timeout_o !== 1'b0 || bus.mem_read_o !== 1'b1) cnt_a++;
    end
    chk("fetch_retry_no_early_to", 32'(cnt_a), 32'd0);
    step(6'd0, 6'd0, 1'b0, 1'b0);
    chk("fetch_retry_to", 32'(bus.timeout_o), 32'd1);

    // Asynchronous reset during an lw MEM wait
    do_reset();
    step(6'd0, 6'd0, 1'b1, 1'b0);
    step(6'd35, 6'd0, 1'b1, 1'b0);
    step(6'd0, 6'd0, 1'b1, 1'b0);
    step(6'd0, 6'd0, 1'b0, 1'b0);
    chk("mem_wait_before_rst", 32'({bus.state_o, bus.mem_read_o}), 32'({SMem, 1'b1}));
    #1 rst_n = 1'b0;
    #1 chk("mem_wait_async_rst", 32'(act), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mem_rst_idle", 32'(bus.state_o), 32'(SIdle));
    @(posedge clk); #1;
    chk("mem_rst_fetch", 32'(bus.state_o), 32'(SFetch));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
